// File: rtl/compare_search.sv
// compare_search: 4-bit binary search driving an external comparator; optional probe counter under SEARCH_STEP_COUNT_EN.
module compare_search (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       eq,
    input  logic       greater,
    input  logic       less,
    output logic [3:0] guess,
    output logic       guess_valid,
    output logic       busy,
    output logic       done,
    output logic       found,
    output logic       error,
    output logic [3:0] result,
    output logic [2:0] steps
);
    typedef enum logic [1:0] {IDLE, PROBE, UPDATE, DONE} state_t;
    state_t state;
    logic [4:0] lo, hi, nlo, nhi, sum;
    logic [2:0] flags;
    logic more;
    // hi may reach -1 (5'h1f) after guess 0; bit 4 marks it as below every lo
    always_comb begin
        nlo = flags == 3'b001 ? {1'b0, guess} + 5'd1 : lo;
        nhi = flags == 3'b010 ? {1'b0, guess} - 5'd1 : hi;
        more = !nhi[4] && nlo <= nhi;
        sum = nlo + nhi;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            lo <= 5'd0;
            hi <= 5'd0;
            flags <= 3'd0;
            guess <= 4'd0;
            guess_valid <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            found <= 1'b0;
            error <= 1'b0;
            result <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= PROBE;
                    lo <= 5'd0;
                    hi <= 5'd15;
                    guess <= 4'd7;
                    guess_valid <= 1'b1;
                    busy <= 1'b1;
                    found <= 1'b0;
                    error <= 1'b0;
                    result <= 4'd0;
                end
                PROBE: begin
                    flags <= {eq, greater, less};
                    guess_valid <= 1'b0;
                    state <= UPDATE;
                end
                UPDATE: begin
                    lo <= nlo;
                    hi <= nhi;
                    if (flags == 3'b100) begin
                        found <= 1'b1;
                        result <= guess;
                        state <= DONE;
                    end else if (flags == 3'b010 || flags == 3'b001) begin
                        state <= more ? PROBE : DONE;
                        guess <= more ? sum[4:1] : guess;
                        guess_valid <= more;
                    end else begin
                        error <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
`ifdef SEARCH_STEP_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            steps <= 3'd0;
        else if (state == IDLE && start)
            steps <= 3'd0;
        else if (state == PROBE)
            steps <= steps + 3'd1;
    end
`else
    assign steps = 3'd0;
`endif
endmodule

// File: tb/tb_compare_search.sv
// tb_compare_search: randomized self-checking bench with a behavioural binary-search model.
module tb_compare_search;
    logic clk = 1'b0;
    logic rst, start, eq, greater, less;
    logic [3:0] guess, result;
    logic guess_valid, busy, done, found, error;
    logic [2:0] steps;
    int target;
    logic force_on;
    logic [2:0] force_val;
    int tests = 0, fails = 0;
    int exp_q[$];
    int exp_found, exp_err;
    logic [2:0] bad_flags [5] = '{3'b000, 3'b110, 3'b011, 3'b101, 3'b111};

    compare_search dut (
        .clk(clk), .rst(rst), .start(start), .eq(eq), .greater(greater), .less(less),
        .guess(guess), .guess_valid(guess_valid), .busy(busy), .done(done),
        .found(found), .error(error), .result(result), .steps(steps)
    );

    always #5 clk = ~clk;

    // Comparator against the hidden target; target may lie outside 0..15 to exercise not-found paths
    always_comb begin
        {eq, greater, less} = 3'b000;
        if (force_on)
            {eq, greater, less} = force_val;
        else begin
            eq = int'(guess) == target;
            greater = int'(guess) > target;
            less = int'(guess) < target;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model(input int t, input int fidx, input logic [2:0] fv);
        int lo = 0, hi = 15, g;
        logic [2:0] f;
        exp_q.delete();
        exp_found = 0;
        exp_err = 0;
        while (1) begin
            g = (lo + hi) / 2;
            exp_q.push_back(g);
            f = (exp_q.size() - 1 == fidx) ? fv : {g == t, g > t, g < t};
            if (f == 3'b100) exp_found = 1;
            else if (f == 3'b010) hi = g - 1;
            else if (f == 3'b001) lo = g + 1;
            else exp_err = 1;
            if (exp_found || exp_err || lo > hi) break;
        end
    endtask

    function automatic int exp_steps(input int p);
`ifdef SEARCH_STEP_COUNT_EN
        return p;
`else
        return 0;
`endif
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, " guess"}, guess, 0);
        chk({tag, " guess_valid"}, guess_valid, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " found"}, found, 0);
        chk({tag, " error"}, error, 0);
        chk({tag, " result"}, result, 0);
        chk({tag, " steps"}, steps, 0);
    endtask

    task automatic run(input int t, input int fidx, input logic [2:0] fv, input bit poke);
        int p, last;
        model(t, fidx, fv);
        p = exp_q.size();
        target = t;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k <= 2 * p + 2; k++) begin
            force_on = fidx >= 0 && k == 2 * fidx;
            force_val = fv;
            last = exp_q[(k / 2 < p) ? k / 2 : p - 1];
            chk($sformatf("t%0d k%0d guess_valid", t, k), guess_valid, int'(k % 2 == 0 && k < 2 * p));
            chk($sformatf("t%0d k%0d guess", t, k), guess, last);
            chk($sformatf("t%0d k%0d busy", t, k), busy, int'(k <= 2 * p));
            chk($sformatf("t%0d k%0d done", t, k), done, int'(k == 2 * p + 1));
            if (k >= 2 * p + 1) begin
                chk($sformatf("t%0d k%0d found", t, k), found, exp_found);
                chk($sformatf("t%0d k%0d error", t, k), error, exp_err);
                chk($sformatf("t%0d k%0d result", t, k), result, exp_found ? t : 0);
                chk($sformatf("t%0d k%0d steps", t, k), steps, exp_steps(p));
            end
            start = poke && (k == 3 || k == 4);
            @(negedge clk);
        end
        force_on = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; target = 0; force_on = 1'b0; force_val = 3'b000;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        // pin the model with hand-computed sequences
        model(5, -1, 3'b000);
        chk("model t5 len", exp_q.size(), 3);
        chk("model t5 g0", exp_q[0], 7);
        chk("model t5 g1", exp_q[1], 3);
        chk("model t5 g2", exp_q[2], 5);
        model(15, -1, 3'b000);
        chk("model t15 len", exp_q.size(), 5);
        chk("model t15 g4", exp_q[4], 15);
        model(0, -1, 3'b000);
        chk("model t0 len", exp_q.size(), 4);
        chk("model t0 g3", exp_q[3], 0);
        model(9, 0, 3'b000);
        chk("model err len", exp_q.size(), 1);
        chk("model err flag", exp_err, 1);
        // rst together with start
        @(negedge clk) begin rst = 1'b1; start = 1'b1; end
        @(negedge clk) begin rst = 1'b0; start = 1'b0; end
        @(negedge clk);
        chk("rst+start busy", busy, 0);
        chk("rst+start guess_valid", guess_valid, 0);
        run(5, -1, 3'b000, 1'b0);
        run(15, -1, 3'b000, 1'b0);
        run(0, -1, 3'b000, 1'b0);
        run(9, 0, 3'b000, 1'b0);
        run(-1, -1, 3'b000, 1'b0);
        run(16, -1, 3'b000, 1'b0);
        run(11, -1, 3'b000, 1'b1);
        // reset during the second probe, then a clean search
        target = 9;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid guess before rst", guess, 11);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check_reset_state("mid rst");
        run(9, -1, 3'b000, 1'b0);
        for (int i = 0; i < 40; i++) begin
            int t, fidx;
            t = int'($urandom_range(0, 17)) - 1;
            fidx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
            run(t, fidx, bad_flags[$urandom_range(0, 4)], $urandom_range(0, 3) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/compare_search.md
COMPARE_SEARCH -- requirements
Module: compare_search

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 start  input  1  one-cycle request to begin a search; honoured only in IDLE.
REQ-004 guess  output  4  probe value driven to the external comparator's first operand; the comparator's second operand is the hidden target.
REQ-005 guess_valid  output  1  high while guess is stable and the flags are to be sampled.
REQ-006 eq, greater, less  input  1 each  comparator flags: eq means guess == target, greater means guess > target, less means guess < target.
REQ-007 busy  output  1  high from the cycle after an accepted start until done.
REQ-008 done  output  1  one-cycle pulse at search end.
REQ-009 found  output  1  valid with done and held until the next accepted start: target located.
REQ-010 error  output  1  valid with done and held until the next accepted start: illegal flag combination seen.
REQ-011 result  output  4  located target value, held until the next accepted start.
REQ-012 steps  output  3  number of probes issued in the last search.

Function
REQ-013 The block SHALL be a binary search over the range 0..15 using registered bounds lo and hi (5-bit internally), initialised to lo=0 and hi=15 on an accepted start.
REQ-014 The states SHALL be IDLE, PROBE, UPDATE and DONE.
REQ-015 IDLE to PROBE SHALL occur on the edge where start=1; start in any other state SHALL be ignored.
REQ-016 In PROBE, guess SHALL equal (lo+hi)>>1 and guess_valid=1; eq, greater and less SHALL be registered at the end of PROBE.
REQ-017 PROBE SHALL always go to UPDATE, so each probe costs exactly 2 cycles.
REQ-018 UPDATE, registered flags = eq only: result=guess, found=1, go to DONE.
REQ-019 UPDATE, registered flags = greater only: hi=guess-1.
REQ-020 UPDATE, registered flags = less only: lo=guess+1.
REQ-021 After a bound update, UPDATE SHALL go to PROBE if lo<=hi, else to DONE with found=0 and error=0.
REQ-022 UPDATE SHALL go to DONE with error=1 and found=0 when the registered flags are zero or more than one flag is high.
REQ-023 DONE SHALL assert done for one cycle and then return to IDLE.
REQ-024 guess_valid SHALL be 0 in every state except PROBE.
REQ-025 guess SHALL hold its last value outside PROBE.
REQ-026 The maximum search SHALL be 5 probes (11 cycles from start to the done pulse).
REQ-027 Underflow of hi=guess-1 at guess=0 SHALL be handled by the 5-bit internal compare, never by wrap-around to 15.

Reset
REQ-028 rst=1 SHALL force IDLE with guess=0, guess_valid=0, busy=0, done=0, found=0, error=0, result=0 and steps=0, including when asserted mid-search.
REQ-029 rst=1 together with start=1 SHALL leave the block in IDLE with no search begun.

Configuration
REQ-030 With SEARCH_STEP_COUNT_EN defined, steps SHALL count the probes of the current search (cleared on accepted start, incremented on each PROBE) and hold after done.
REQ-031 Without SEARCH_STEP_COUNT_EN defined, steps SHALL be constant 0 and no counter logic SHALL be present.
REQ-032 The port list SHALL be identical whether or not SEARCH_STEP_COUNT_EN is defined.

Verification
REQ-033 Target 5 -> guesses 7,3,5; found=1, result=5, steps=3, done pulse 7 cycles after the start edge.
REQ-034 Target 15 -> guesses 7,11,13,14,15; found=1, steps=5.
REQ-035 Target 0 -> guesses 7,3,1,0; found=1, result=0, steps=4, no wrap.
REQ-036 Flags forced to 000 on the first probe -> done with error=1, found=0, steps=1.
REQ-037 rst during the 2nd probe -> all outputs at reset values next cycle; a new start then searches correctly.
REQ-038 start pulsed while busy -> ignored, and the in-flight search result is unchanged.
